// File: rtl/save_ram_arbiter.sv
// save_ram_arbiter: shares the single-port result-save RAM between the result writer and a
// burst readout engine with a 2-entry output buffer. Define ARB_FAIR_EN to let a starved reader force a slot.
module save_ram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] rd_len,
    output logic              rd_busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              rd_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    if (STARVE_MAX < 1) begin : g_starve_chk
        $error("STARVE_MAX must be at least 1");
    end

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              rd_done_q;
    logic              inflight_q;
    logic [DATA_W-1:0] buf_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        buf_count;

    logic force_rd;
    logic write_slot;
    logic rd_issue;
    logic pop;
    logic credit_ok;
    logic last_issue;
    logic drain_done;

    assign pop = (buf_count != 2'd0) && rd_ready;
    // A word leaving the buffer this cycle frees its slot, which keeps a ready consumer fed every cycle.
    assign credit_ok  = ({1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;
    assign write_slot = wr_req && !force_rd;
    assign rd_issue   = (state == S_BURST) && !write_slot && credit_ok;
    assign last_issue = rd_issue && (cnt_q == len_q - ADDR_W'(1));
    // Look ahead so rd_done rises right after the final handshake, not one cycle later.
    assign drain_done = (state == S_DRAIN) && !inflight_q && (buf_count == {1'b0, pop});

    assign wr_gnt   = write_slot;
    assign ram_en   = write_slot || rd_issue;
    assign ram_we   = write_slot;
    assign ram_din  = wr_data;
    assign rd_busy  = (state != S_IDLE);
    assign rd_valid = (buf_count != 2'd0);
    assign rd_data  = buf_mem[rd_ptr];
    assign rd_done  = rd_done_q;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        ram_addr = '0;
        if (write_slot) ram_addr = wr_addr;
        else if (rd_issue) ram_addr = base_q + cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rd_done_q <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_start) begin
                        base_q <= rd_base;
                        len_q  <= rd_len;
                        cnt_q  <= '0;
                        if (rd_len == '0) rd_done_q <= 1'b1;
                        else state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (rd_issue) begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                        if (last_issue) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        rd_done_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the two buffer words are reset as well; it is tiny and keeps rd_data at 0 out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            buf_count  <= 2'd0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            inflight_q <= rd_issue;
            if (inflight_q) begin
                buf_mem[wr_ptr] <= ram_dout;
                wr_ptr          <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            buf_count <= buf_count + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

`ifdef ARB_FAIR_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve_q;
    logic                read_eligible;

    assign read_eligible = (state == S_BURST) && credit_ok;
    assign force_rd      = read_eligible && (starve_q == STARVE_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) starve_q <= '0;
        else if (rd_issue || state != S_BURST) starve_q <= '0;
        else if (read_eligible && wr_req) starve_q <= starve_q + STARVE_W'(1);
    end
`else
    assign force_rd = 1'b0;
`endif

endmodule
